// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int DMEM_CNT_W   = 4;
  localparam int DMEM_LATENCY = 4;
  localparam int DMEM_AW      = 12;

endpackage

// File: rtl/dmem_array.sv
// Single-port 2^AW x 16 storage with synchronous read and write, no reset.
module dmem_array #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1<<AW)-1];

  // rdata only moves on a read, so it holds the last loaded word across writes
  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-memory responder: latches a load/store, stalls the core for LATENCY
// busy cycles, performs the access and pulses rdy for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY = DMEM_LATENCY,
  parameter int AW      = DMEM_AW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wrt_data,
  output logic [15:0] rd_data,
  output logic        stall,
  output logic        rdy
);

  localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_t           state_reg, state_next;
  logic [DMEM_CNT_W-1:0] cnt_reg;
  logic [AW-1:0]         addr_reg;
  logic [15:0]           data_reg;
  logic                  wr_op_reg;
  logic                  rd_valid_reg;
  logic                  req;
  logic                  mem_en;
  logic [15:0]           mem_rdata;

  assign req = re | we;

  // Upper address bits alias onto the decoded range and are deliberately dropped
  generate
    if (AW < 16) begin : g_addr_alias
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[15:AW];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gating the array enable with rst_n aborts a pending write on a reset edge
  always_comb begin
    stall  = 1'b0;
    rdy    = 1'b0;
    mem_en = 1'b0;
    case (state_reg)
      IDLE: stall = req;
      BUSY: begin
        stall  = 1'b1;
        mem_en = (cnt_reg == '0) && rst_n;
      end
      DONE: rdy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && req) begin
        cnt_reg <= CNT_INIT;
      end else if (state_reg == BUSY && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (mem_en && !wr_op_reg) begin
        rd_valid_reg <= 1'b1;
      end
    end
  end

  // Request latches need no reset: they are only consumed after an acceptance
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && req) begin
      addr_reg  <= addr[AW-1:0];
      data_reg  <= wrt_data;
      wr_op_reg <= we;
    end
  end

  dmem_array #(
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .wr   (wr_op_reg),
    .addr (addr_reg),
    .wdata(data_reg),
    .rdata(mem_rdata)
  );

  // The array's read register holds between loads; rd_valid masks it to zero after reset
  assign rd_data = rd_valid_reg ? mem_rdata : 16'h0000;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data-memory port. It services the CPU's single-cycle-style load/store requests (addr/re/we/wrt_data) with a configurable multi-cycle access latency. It holds the core with a `stall` output until each access completes, then returns load data. It sits between the CPU datapath and the data storage array and replaces the zero-latency data memory when realistic memory timing is modelled.

## Interface
Parameters:
- `LATENCY`, default 4: cycles spent in BUSY per access; legal range 1..15.
- `AW`, default 12: word-address bits actually decoded; storage is 2^AW x 16-bit words.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `addr`, input, 16: word address from the ALU result.
- `re`, input, 1: load request.
- `we`, input, 1: store request.
- `wrt_data`, input, 16: store data (register-file port 1).
- `rd_data`, output, 16: load data, registered.
- `stall`, output, 1: hold PC and pipeline state while high.
- `rdy`, output, 1: one-cycle pulse when an access has completed.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**: if `re|we`, latch `addr[AW-1:0]`, `wrt_data`, and op (write if `we`, else read). Load `cnt <= LATENCY-1`, go to BUSY. `stall` is combinationally high in this same cycle (`stall = IDLE & (re|we)`). With no request, remain in IDLE and keep `stall=0`.
- **BUSY**: `stall=1`. Decrement `cnt` each cycle. When `cnt==0`, perform the access at the clock edge and go to DONE:
  - write: `mem[latched addr] <= latched data`;
  - read: `rd_data <= mem[latched addr]`.
- **DONE**: `stall=0`, `rdy=1`, `rd_data` valid. Inputs are ignored this cycle, because the CPU still presents the same request while its PC advances. Go to IDLE unconditionally.
- `re` and `we` both high: treated as a write; `rd_data` is unchanged.
- Address bits `[15:AW]` are ignored, so addresses alias with wrap modulo 2^AW.
- `rd_data` holds its last value until the next completed read; writes never modify it.
- Inputs that change during BUSY have no effect; only the values latched at acceptance are used.

## Timing
- Reset values (`rst_n` low at an edge): state=IDLE, `cnt=0`, `rd_data=16'h0000`, `rdy=0`. `stall` is then 0 unless a request is present in IDLE.
- Reset mid-operation: the access is aborted and the pending write does not occur. Memory contents are not cleared by reset.
- Request accepted in cycle 0 gives:
  - `stall` high for cycles 0..LATENCY (LATENCY+1 cycles);
  - access at the end of cycle LATENCY;
  - `rdy` and valid `rd_data` in cycle LATENCY+1.
- With LATENCY=1: stall in cycles 0–1, DONE in cycle 2.
- Back-to-back requests: minimum spacing is LATENCY+2 cycles (accept, BUSY×LATENCY, DONE). A request present in DONE is only accepted in the following IDLE cycle.
- Storage is a single port with synchronous write and synchronous read, used only at the BUSY→DONE edge.

## Structure
- Shared package `dmem_pkg` holds:
  - the state typedef `dmem_state_t` {IDLE, BUSY, DONE};
  - `DMEM_CNT_W = 4`;
  - the default `LATENCY` and `AW` constants.
- Sub-module `dmem_array`: parameterised by `AW`. Ports are `clk`, `en`, `wr`, `addr[AW-1:0]`, `wdata[15:0]`, `rdata[15:0]`. It provides synchronous read and write and has no reset.
- Top: FSM, counter, request latches, and the `rd_data` register (or a direct registered output from `dmem_array`, qualified by op).

## Test plan
- Reset, then idle for 5 cycles with no request → `stall=0`, `rdy=0`, `rd_data=0000`.
- Store `addr=0x0010`, `wrt_data=0xBEEF` (LATENCY=4), then load `0x0010` → first request stalls cycles 0–4 with `rdy` in cycle 5. Load returns `0xBEEF` 5 cycles after acceptance, with exactly one `rdy` pulse per access.
- Request held high through DONE (CPU not yet advanced) → no second acceptance; the next accept occurs only in the following IDLE cycle.
- `re=we=1`, `addr=0x1005`, `wrt_data=0x1234` (AW=12), then load `0x0005` → write performed, `rd_data` unchanged after the first access, load returns `0x1234` (aliasing).
- Start a store to `0x0020` of `0xAAAA`, assert `rst_n=0` in BUSY cycle 2, then load `0x0020` → prior contents returned (not `0xAAAA`), and state is IDLE, `rdy=0`, `rd_data=0` immediately after reset.
- LATENCY=1 build: load of a preloaded `0x00FF` word → `stall` high for 2 cycles, `rdy` and data in cycle 2.
